// File: rtl/dmem_write_buffer_if.sv
// dmem_write_buffer_if: line-granular read/write bus with a one-cycle ready pulse
interface dmem_write_buffer_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    modport master (output read, write, addr, wdata, input rdata, ready);
    modport slave (input read, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posted line-write FIFO with read forwarding; DMEM_WBUF_COALESCE_EN merges writes to a buffered line
module dmem_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dmem_write_buffer_if.slave     c_bus,
    dmem_write_buffer_if.master    m_bus,
    output logic                   wb_empty_o,
    output logic [$clog2(DEPTH):0] wb_count_o
);
    localparam int PW = $clog2(DEPTH);
`ifdef DMEM_WBUF_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} state_t;
    state_t            state_q, state_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [PW:0]       count_q, count_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic              hit;
    logic [PW-1:0]     hit_idx;
    logic              wr_en;
    logic [PW-1:0]     wr_idx;

    // scan oldest to youngest so the youngest matching entry wins
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((PW+1)'(k) < count_q && addr_mem_q[head_q + PW'(k)] == c_bus.addr) begin
                hit     = 1'b1;
                hit_idx = head_q + PW'(k);
            end
        end
    end

    // next state: cache requests are only looked at in IDLE; drains are never aborted
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        raddr_d = raddr_q;
        rdata_d = rdata_q;
        wr_en   = 1'b0;
        wr_idx  = tail_q;
        case (state_q)
            IDLE: begin
                if (c_bus.read) begin
                    if (hit) begin
                        rdata_d = data_mem_q[hit_idx];
                        state_d = RESP;
                    end else begin
                        raddr_d = c_bus.addr;
                        state_d = READ;
                    end
                end else if (c_bus.write) begin
                    if (COALESCE && hit) begin
                        wr_en   = 1'b1;
                        wr_idx  = hit_idx;
                        state_d = RESP;
                    end else if (count_q != (PW+1)'(DEPTH)) begin
                        wr_en   = 1'b1;
                        tail_d  = tail_q + 1'b1;
                        count_d = count_q + 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (count_q != '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (m_bus.ready) begin
                    head_d  = head_q + 1'b1;
                    count_d = count_q - 1'b1;
                    state_d = IDLE;
                end
            end
            READ: begin
                if (m_bus.ready) begin
                    rdata_d = m_bus.rdata;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // control registers; reset drops any buffered lines and in-flight transaction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            raddr_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            raddr_q <= raddr_d;
            rdata_q <= rdata_d;
        end
    end

    // line storage; validity is carried by head/count so no reset is needed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            addr_mem_q[wr_idx] <= c_bus.addr;
            data_mem_q[wr_idx] <= c_bus.wdata;
        end
    end

    assign c_bus.ready = state_q == RESP;
    assign c_bus.rdata = rdata_q;
    assign m_bus.write = state_q == DRAIN;
    assign m_bus.read  = state_q == READ;
    assign m_bus.addr  = state_q == DRAIN ? addr_mem_q[head_q] : state_q == READ ? raddr_q : '0;
    assign m_bus.wdata = state_q == DRAIN ? data_mem_q[head_q] : '0;
    assign wb_empty_o  = count_q == '0;
    assign wb_count_o  = count_q;
endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb_dmem_write_buffer: directed tests against a queue-based transaction model of the write buffer
module tb_dmem_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 28;
    localparam int DW    = 128;
`ifdef DMEM_WBUF_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif
    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wb_empty;
    logic [2:0] wb_count;
    int total = 0;
    int bad = 0;
    int mem_lat = 5;
    int mcnt = 0;
    ent_t mq[$];
    logic [AW:0] mlog[$];
    logic op_rd = 1'b0;
    logic [AW-1:0] op_addr = '0;
    logic [DW-1:0] op_data = '0;

    always #5 clk = ~clk;

    dmem_write_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) c_bus ();
    dmem_write_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) m_bus ();

    dmem_write_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .c_bus(c_bus),
        .m_bus(m_bus),
        .wb_empty_o(wb_empty),
        .wb_count_o(wb_count)
    );

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] wd(input int n);
        return {4{32'hA5A5_0000 + 32'(n)}};
    endfunction

    function automatic logic [DW-1:0] rd_pattern(input logic [AW-1:0] a);
        return {4{32'hD00D_0000 | 32'(a)}};
    endfunction

    function automatic bit find(input logic [AW-1:0] a, output logic [DW-1:0] d);
        find = 1'b0;
        d = '0;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].a == a) begin
                find = 1'b1;
                d = mq[i].d;
            end
    endfunction

    // memory model: fixed latency in cycles, then a one-cycle ready pulse
    initial begin
        m_bus.ready = 1'b0;
        m_bus.rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || m_bus.ready) begin
                m_bus.ready = 1'b0;
                mcnt = 0;
            end else if (m_bus.read || m_bus.write) begin
                mcnt++;
                if (mcnt >= mem_lat) begin
                    m_bus.ready = 1'b1;
                    mcnt = 0;
                    if (m_bus.read) m_bus.rdata = rd_pattern(m_bus.addr);
                end
            end
        end
    end

    // per-cycle compare against the transaction model
    logic prev_ready = 1'b0;
    bit pop_pending = 1'b0;
    always @(negedge clk) begin
        logic [DW-1:0] fd;
        bit f;
        int hi;
        if (!rst_n) begin
            mq.delete();
            pop_pending = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (pop_pending) begin
                void'(mq.pop_front());
                pop_pending = 1'b0;
            end
            if (c_bus.ready) begin
                check("c_ready_single", prev_ready, 0);
                if (op_rd) begin
                    f = find(op_addr, fd);
                    check("c_rdata", c_bus.rdata, f ? fd : rd_pattern(op_addr));
                end else begin
                    hi = -1;
                    if (COAL)
                        for (int i = 0; i < mq.size(); i++) if (mq[i].a == op_addr) hi = i;
                    if (hi >= 0) mq[hi].d = op_data;
                    else mq.push_back('{a: op_addr, d: op_data});
                end
            end
            prev_ready = c_bus.ready;
            check("wb_count", wb_count, mq.size());
            check("wb_empty", wb_empty, mq.size() == 0);
            check("m_rw_exclusive", m_bus.read & m_bus.write, 0);
            if (m_bus.write) begin
                check("m_write_addr", m_bus.addr, mq.size() > 0 ? DW'(mq[0].a) : '1);
                check("m_write_data", m_bus.wdata, mq.size() > 0 ? mq[0].d : '1);
                if (m_bus.ready) begin
                    pop_pending = 1'b1;
                    mlog.push_back({1'b1, m_bus.addr});
                end
            end
            if (m_bus.read) begin
                f = find(op_addr, fd);
                check("m_read_on_hit", f, 0);
                check("m_read_addr", m_bus.addr, op_addr);
                if (m_bus.ready) mlog.push_back({1'b0, m_bus.addr});
            end
        end
    end

    task automatic cache_op(input bit rd, input bit wr, input int a, input logic [DW-1:0] d,
                            output int n, output logic [DW-1:0] q);
        @(posedge clk);
        #1;
        op_rd = rd;
        op_addr = AW'(a);
        op_data = d;
        c_bus.read = rd;
        c_bus.write = wr;
        c_bus.addr = AW'(a);
        c_bus.wdata = d;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!c_bus.ready && n < 300);
        check("c_ready_timeout", c_bus.ready, 1);
        q = c_bus.rdata;
        c_bus.read = 1'b0;
        c_bus.write = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((!wb_empty || m_bus.write || m_bus.read) && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", wb_empty, 1);
    endtask

    task automatic wait_mwrite();
        int n = 0;
        while (!m_bus.write && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("m_write_timeout", m_bus.write, 1);
    endtask

    task automatic log_is(input int i, input bit w, input int a);
        check($sformatf("mlog[%0d]", i), (i < mlog.size()) ? DW'(mlog[i]) : '1, {w, AW'(a)});
    endtask

    initial begin
        int n;
        logic [DW-1:0] q;
        c_bus.read = 1'b0;
        c_bus.write = 1'b0;
        c_bus.addr = '0;
        c_bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_wb_empty", wb_empty, 1);
        check("rst_wb_count", wb_count, 0);
        check("rst_m_read", m_bus.read, 0);
        check("rst_m_write", m_bus.write, 0);
        check("rst_c_ready", c_bus.ready, 0);
        check("rst_c_rdata", c_bus.rdata, 0);
        check("rst_m_addr", m_bus.addr, 0);
        check("rst_m_wdata", m_bus.wdata, 0);
        repeat (4) @(negedge clk);

        // single write, then drain
        mem_lat = 5;
        mlog.delete();
        cache_op(0, 1, 'h10, wd(1), n, q);
        check("t2_latency", n, 1);
        check("t2_count", wb_count, 1);
        wait_mwrite();
        check("t2_m_addr", m_bus.addr, 'h10);
        check("t2_m_wdata", m_bus.wdata, wd(1));
        wait_empty();
        check("t2_log_len", mlog.size(), 1);
        log_is(0, 1, 'h10);

        // read hit is forwarded without touching memory
        mem_lat = 30;
        mlog.delete();
        cache_op(0, 1, 'h10, wd(2), n, q);
        cache_op(1, 0, 'h10, '0, n, q);
        check("t3_latency", n, 1);
        check("t3_rdata", q, wd(2));
        check("t3_count", wb_count, 1);
        wait_empty();
        check("t3_log_len", mlog.size(), 1);
        log_is(0, 1, 'h10);

        // read miss waits for the in-flight drain, then bypasses the remaining write
        mem_lat = 4;
        mlog.delete();
        cache_op(0, 1, 'h20, wd(3), n, q);
        cache_op(0, 1, 'h30, wd(4), n, q);
        wait_mwrite();
        cache_op(1, 0, 'h40, '0, n, q);
        check("t4_rdata", q, {4{32'hD00D_0040}});
        wait_empty();
        check("t4_log_len", mlog.size(), 3);
        log_is(0, 1, 'h20);
        log_is(1, 0, 'h40);
        log_is(2, 1, 'h30);

        // full buffer: fifth write waits for the head drain; tail wraps
        mem_lat = 3;
        mlog.delete();
        for (int i = 1; i <= 4; i++) begin
            cache_op(0, 1, i, wd(10 + i), n, q);
            check("t5_fill_latency", n, 1);
        end
        check("t5_full_count", wb_count, 4);
        cache_op(0, 1, 5, wd(15), n, q);
        check("t5_full_latency", n, 5);
        check("t5_log_at_accept", mlog.size(), 1);
        cache_op(1, 0, 5, '0, n, q);
        check("t5_wrap_rdata", q, wd(15));
        wait_empty();
        check("t5_log_len", mlog.size(), 5);
        for (int i = 0; i < 5; i++) log_is(i, 1, i + 1);

        // same-line writes: coalesced or appended
        mem_lat = 20;
        mlog.delete();
        cache_op(0, 1, 'h7, wd(20), n, q);
        cache_op(0, 1, 'h7, wd(21), n, q);
        check("t6_count", wb_count, COAL ? 1 : 2);
        cache_op(1, 0, 'h7, '0, n, q);
        check("t6_rdata", q, wd(21));
        wait_empty();
        check("t6_log_len", mlog.size(), COAL ? 1 : 2);
        log_is(0, 1, 'h7);
        if (!COAL) log_is(1, 1, 'h7);
`ifdef DMEM_WBUF_COALESCE_EN
        mlog.delete();
        for (int i = 1; i <= 4; i++) cache_op(0, 1, 'h100 + i, wd(30 + i), n, q);
        cache_op(0, 1, 'h102, wd(40), n, q);
        check("t6_full_coalesce_latency", n, 1);
        check("t6_full_coalesce_count", wb_count, 4);
        wait_empty();
        check("t6_full_log_len", mlog.size(), 4);
`endif

        // read and write together is treated as a read
        mem_lat = 30;
        mlog.delete();
        cache_op(0, 1, 'h50, wd(50), n, q);
        cache_op(1, 1, 'h50, wd(51), n, q);
        check("t7_latency", n, 1);
        check("t7_rdata", q, wd(50));
        check("t7_count", wb_count, 1);
        wait_empty();

        // reset during a drain discards everything
        mem_lat = 10;
        mlog.delete();
        cache_op(0, 1, 'h60, wd(60), n, q);
        wait_mwrite();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t8_m_write", m_bus.write, 0);
        check("t8_count", wb_count, 0);
        check("t8_empty", wb_empty, 1);
        check("t8_m_addr", m_bus.addr, 0);
        check("t8_m_wdata", m_bus.wdata, 0);
        check("t8_c_rdata", c_bus.rdata, 0);
        check("t8_c_ready", c_bus.ready, 0);
        repeat (20) @(negedge clk);
        check("t8_log_len", mlog.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end
endmodule
